mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch port (IF stage) and the data port (MEM stage) of the 5-stage, 16-bit pipeline.
- Sequences fixed-latency memory transactions and produces per-port stall signals. The pipeline holds its request stable while the stall is high.
- Sits between the IF/MEM stages and the memory macro, alongside the hazard detection unit. Its stalls are ORed into the pipeline freeze logic.

Parameters:
- LATENCY, 2, cycles from issue (mem_en high) to mem_rdata valid; legal range 1..15.
- STARVE_MAX, 4, consecutive data grants with if_req pending before IF is forced (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- if_req  input  1  instruction fetch request.
- if_addr  input  16  fetch address.
- if_rdata  output  16  fetched instruction.
- if_ready  output  1  one-cycle completion pulse for fetch.
- if_stall  output  1  fetch port waiting.
- dm_re  input  1  data read request.
- dm_we  input  1  data write request.
- dm_addr  input  16  data address.
- dm_wdata  input  16  write data.
- dm_rdata  output  16  read data.
- dm_ready  output  1  one-cycle completion pulse for data.
- dm_stall  output  1  data port waiting.
- mem_en  output  1  one-cycle issue strobe to memory.
- mem_we  output  1  write enable, valid with mem_en.
- mem_addr  output  16  address, valid with mem_en.
- mem_wdata  output  16  write data, valid with mem_en.
- mem_rdata  input  16  memory read data, valid LATENCY cycles after issue.

Behaviour:
- States: IDLE, WAIT_I, WAIT_D. A 4-bit down counter cnt tracks latency.
- IDLE transitions:
  - if (dm_re|dm_we): issue data transaction. mem_en=1, mem_we=dm_we, mem_addr=dm_addr, mem_wdata=dm_wdata. Load cnt=LATENCY-1. Go to WAIT_D.
  - else if if_req: issue fetch. mem_en=1, mem_we=0, mem_addr=if_addr. Load cnt=LATENCY-1. Go to WAIT_I.
  - else stay in IDLE, mem_en=0.
- Data has strict priority over fetch, because the older instruction must make progress.
- WAIT_x, cnt!=0: decrement cnt. mem_en=0.
- WAIT_x, cnt==0 (completion cycle):
  - x_ready=1 combinationally.
  - x_rdata=mem_rdata, and it is also captured in a hold register that drives x_rdata until the next completion on that port.
  - Next state is IDLE.
  - Issue occurs no earlier than the cycle after completion, so one transaction completes every LATENCY+1 cycles.
- Writes complete identically. dm_ready pulses and dm_rdata holds its previous value.
- Stalls are combinational:
  - if_stall = if_req & ~if_ready.
  - dm_stall = (dm_re|dm_we) & ~dm_ready.
- Ready is high for exactly one cycle per transaction and never high on both ports in the same cycle.
- dm_re and dm_we both high is treated as a write; dm_rdata is unchanged.
- A request deasserted during WAIT does not abort the transaction. Completion still pulses ready and the requester ignores it.
- mem_addr, mem_we and mem_wdata are driven 0 when mem_en=0.
- Reset (any cycle, including mid-transaction):
  - state=IDLE, cnt=0.
  - mem_en=0, if_ready=0, dm_ready=0.
  - if_rdata=16'h0000, dm_rdata=16'h0000.
  - The outstanding transaction is dropped and its late mem_rdata is ignored.

Optional Feature:
- Macro MEM_ARB_STARVE_GUARD_EN.
- Defined: a 4-bit counter starve_cnt increments on each data issue while if_req is high. It clears on any fetch issue and on reset. When starve_cnt==STARVE_MAX and if_req is high, IDLE issues the fetch even if a data request is present.
- Undefined: strict data priority; no counter is present.

Decomposition:
- Shared header mem_arb_defs.vh holds:
  - state encodings ST_IDLE=2'd0, ST_WAIT_I=2'd1, ST_WAIT_D=2'd2;
  - the 16-bit word width constant.
- One natural sub-module, lat_counter: load/decrement/zero-flag counter, reused for the starvation counter.

Test Plan:
- LATENCY=2, if_req=1, if_addr=16'h0010, mem returns 16'hB123: mem_en at cycle 0; if_ready and if_rdata=16'hB123 at cycle 2; if_stall high at cycles 0-1.
- if_req and dm_re both high in IDLE (dm_addr=16'h0040): data issues first and dm_ready pulses at cycle 2; fetch issues at cycle 3 and if_ready pulses at cycle 5.
- dm_we=1, dm_addr=16'h0044, dm_wdata=16'h5A5A: mem_we=1 with mem_en; dm_ready at cycle 2; dm_rdata unchanged.
- rst asserted at cycle 1 of a fetch: state IDLE, if_ready never pulses for that fetch, and all outputs read 0 after the reset edge.
- With MEM_ARB_STARVE_GUARD_EN, STARVE_MAX=4, dm_re and if_req held high: the fifth grant goes to fetch. With the macro undefined: fetch is never granted while dm_re is high.
- LATENCY=1, back-to-back fetches: mem_en every other cycle; if_ready at cycles 1, 3, 5.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter: word width and
// the arbiter state encoding.
package mem_arbiter_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_I = 2'd1,
    ST_WAIT_D = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// Loadable down counter with a zero flag; decrement saturates at zero.
// Used for transaction latency and for the fetch starvation budget.
module lat_counter #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between the fetch and data ports.
// Define MEM_ARB_STARVE_GUARD_EN to force a fetch after STARVE_MAX data grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  if_req,
  input  word_t if_addr,
  output word_t if_rdata,
  output logic  if_ready,
  output logic  if_stall,
  input  logic  dm_re,
  input  logic  dm_we,
  input  word_t dm_addr,
  input  word_t dm_wdata,
  output word_t dm_rdata,
  output logic  dm_ready,
  output logic  dm_stall,
  output logic  mem_en,
  output logic  mem_we,
  output word_t mem_addr,
  output word_t mem_wdata,
  input  word_t mem_rdata
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("mem_arbiter: LATENCY must be in 1..15");
  end
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("mem_arbiter: STARVE_MAX must be in 1..15");
  end

  state_e state_q, state_d;
  word_t  if_hold_q, if_hold_d;
  word_t  dm_hold_q, dm_hold_d;
  logic   wr_q;
  logic   lat_load, lat_dec, lat_zero;
  logic   dm_any, force_if;

  assign dm_any = dm_re | dm_we;

  lat_counter #(.W(4), .RST_VAL(4'd0)) u_lat (
    .clk       (clk),
    .rst       (rst),
    .load_i    (lat_load),
    .load_val_i(4'(LATENCY - 1)),
    .dec_i     (lat_dec),
    .zero_o    (lat_zero)
  );

`ifdef MEM_ARB_STARVE_GUARD_EN
  // Counts down the data grants fetch may still lose; zero means fetch wins next.
  logic fetch_issue, data_issue_starving, starve_zero;
  assign fetch_issue         = mem_en & (state_d == ST_WAIT_I);
  assign data_issue_starving = mem_en & (state_d == ST_WAIT_D) & if_req;

  lat_counter #(.W(4), .RST_VAL(4'(STARVE_MAX))) u_starve (
    .clk       (clk),
    .rst       (rst),
    .load_i    (fetch_issue),
    .load_val_i(4'(STARVE_MAX)),
    .dec_i     (data_issue_starving),
    .zero_o    (starve_zero)
  );
  assign force_if = if_req & starve_zero;
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    lat_load  = 1'b0;
    lat_dec   = 1'b0;
    if_ready  = 1'b0;
    dm_ready  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (dm_any && !force_if) begin
          mem_en    = 1'b1;
          mem_we    = dm_we;
          mem_addr  = dm_addr;
          mem_wdata = dm_wdata;
          lat_load  = 1'b1;
          state_d   = ST_WAIT_D;
        end else if (if_req) begin
          mem_en    = 1'b1;
          mem_addr  = if_addr;
          lat_load  = 1'b1;
          state_d   = ST_WAIT_I;
        end
      end
      ST_WAIT_I: begin
        if (lat_zero) begin
          if_ready = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          lat_dec = 1'b1;
        end
      end
      ST_WAIT_D: begin
        if (lat_zero) begin
          dm_ready = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          lat_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset drops any in-flight transaction, including one completing now.
    if (rst) begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      lat_load  = 1'b0;
      if_ready  = 1'b0;
      dm_ready  = 1'b0;
    end

    if_hold_d = if_ready ? mem_rdata : if_hold_q;
    dm_hold_d = (dm_ready && !wr_q) ? mem_rdata : dm_hold_q;
    if_rdata  = if_hold_d;
    dm_rdata  = dm_hold_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      if_hold_q <= '0;
      dm_hold_q <= '0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      if_hold_q <= if_hold_d;
      dm_hold_q <= dm_hold_d;
      if (mem_en) wr_q <= mem_we;
    end
  end

  assign if_stall = if_req & ~if_ready;
  assign dm_stall = dm_any & ~dm_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model plus directed vectors,
// a LATENCY=2 instance and a LATENCY=1 instance.
module tb_mem_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, dm_re = 1'b0, dm_we = 1'b0;
  logic [15:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, if_stall, dm_ready, dm_stall, mem_en, mem_we;

  logic        b_if_req = 1'b0;
  logic [15:0] b_if_addr = '0, b_mem_rdata = '0;
  logic        b_dm_re = 1'b0, b_dm_we = 1'b0;
  logic [15:0] b_dm_addr = '0, b_dm_wdata = '0;
  logic [15:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;
  logic        b_if_ready, b_if_stall, b_dm_ready, b_dm_stall, b_mem_en, b_mem_we;

  int vecs  = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(LAT), .STARVE_MAX(SMAX)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .if_stall(if_stall),
    .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.LATENCY(1), .STARVE_MAX(SMAX)) u_lat1 (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata),
    .if_ready(b_if_ready), .if_stall(b_if_stall),
    .dm_re(b_dm_re), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_rdata(b_dm_rdata), .dm_ready(b_dm_ready), .dm_stall(b_dm_stall),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory contents, shared by the memory responder and the model.
  logic [15:0] mem [256];

  // Model state: one outstanding transaction that completes at cycle 'done'.
  int          cyc = 0;
  bit          busy = 0, bdata = 0, bread = 0;
  logic [15:0] baddr = '0;
  int          done = 0;
  logic [15:0] hold_if = '0, hold_dm = '0;
  int          starve = 0;
  logic [15:0] nxt_rdata = 16'hDEAD;
  bit          hv [16];
  logic [15:0] ha [16];

  always @(posedge clk) mem_rdata <= nxt_rdata;

  always @(negedge clk) begin
    logic        e_en, e_we, e_ir, e_dr, force_f;
    logic [15:0] e_addr, e_wd, e_ird, e_drd, rd;
    int          k;
    e_en = 0; e_we = 0; e_addr = '0; e_wd = '0; e_ir = 0; e_dr = 0;
    e_ird = hold_if; e_drd = hold_dm;
    if (rst) begin
      busy   = 0;
      starve = 0;
    end else if (busy) begin
      if (cyc == done) begin
        rd = mem[baddr[7:0]];
        if (bdata) begin
          e_dr = 1;
          if (bread) e_drd = rd;
        end else begin
          e_ir  = 1;
          e_ird = rd;
        end
        busy = 0;
      end
    end else begin
      force_f = GUARD && if_req && (starve == SMAX);
      if ((dm_re || dm_we) && !force_f) begin
        e_en = 1; e_we = dm_we; e_addr = dm_addr; e_wd = dm_wdata;
        busy = 1; bdata = 1; bread = !dm_we; baddr = dm_addr; done = cyc + LAT;
        if (if_req) starve++;
      end else if (if_req) begin
        e_en = 1; e_addr = if_addr;
        busy = 1; bdata = 0; bread = 1; baddr = if_addr; done = cyc + LAT;
        starve = 0;
      end
    end

    chk("mem_bus", {30'd0, mem_en, mem_we, mem_addr, mem_wdata}, {30'd0, e_en, e_we, e_addr, e_wd});
    chk("ready", {if_ready, dm_ready}, {e_ir, e_dr});
    chk("stall", {if_stall, dm_stall}, {if_req & ~e_ir, (dm_re | dm_we) & ~e_dr});
    chk("if_rdata", if_rdata, e_ird);
    chk("dm_rdata", dm_rdata, e_drd);

    hold_if = rst ? 16'h0000 : e_ird;
    hold_dm = rst ? 16'h0000 : e_drd;

    // Memory responder: writes land at issue, reads return LAT cycles later.
    if (mem_en === 1'b1) begin
      if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
      hv[cyc % 16] = !mem_we;
      ha[cyc % 16] = mem_addr;
    end else begin
      hv[cyc % 16] = 0;
    end
    k = (cyc + 1 - LAT + 16) % 16;
    nxt_rdata = hv[k] ? mem[ha[k][7:0]] : 16'hDEAD;
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ngr, nfetch, first_f;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[8'h10] = 16'hB123;
    mem[8'h12] = 16'hC0DE;
    mem[8'h40] = 16'h7777;

    // Reset
    step();
    @(negedge clk);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_ready", {if_ready, dm_ready}, 2'b00);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("rst_rdata", {if_rdata, dm_rdata}, 32'h0);

    // Single fetch
    step(); if_req = 1; if_addr = 16'h0010;
    @(negedge clk);
    chk("t1_c0_issue", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 16'h0010});
    chk("t1_c0_stall", if_stall, 1'b1);
    step(); @(negedge clk);
    chk("t1_c1", {if_stall, mem_en, if_ready}, 3'b100);
    step(); @(negedge clk);
    chk("t1_c2_ready", {if_ready, if_stall}, 2'b10);
    chk("t1_c2_rdata", if_rdata, 16'hB123);
    step(); if_req = 0;
    @(negedge clk);
    chk("t1_hold", {mem_en, if_ready, if_rdata}, {2'b00, 16'hB123});

    // Data and fetch together: data first
    step(); if_req = 1; if_addr = 16'h0012; dm_re = 1; dm_addr = 16'h0040;
    @(negedge clk);
    chk("t2_c0_issue", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 16'h0040});
    chk("t2_c0_stall", {if_stall, dm_stall}, 2'b11);
    step(); step(); @(negedge clk);
    chk("t2_c2_ready", {dm_ready, if_ready, if_stall}, 3'b101);
    chk("t2_c2_rdata", dm_rdata, 16'h7777);
    step(); dm_re = 0;
    @(negedge clk);
    chk("t2_c3_fetch", {mem_en, mem_addr}, {1'b1, 16'h0012});
    step(); step(); @(negedge clk);
    chk("t2_c5_ready", {if_ready, if_rdata}, {1'b1, 16'hC0DE});
    step(); if_req = 0;

    // Write, then read back
    step(); dm_we = 1; dm_addr = 16'h0044; dm_wdata = 16'h5A5A;
    @(negedge clk);
    chk("t3_issue", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 16'h0044, 16'h5A5A});
    step(); step(); @(negedge clk);
    chk("t3_ready", {dm_ready, dm_rdata}, {1'b1, 16'h7777});
    step(); dm_we = 0; dm_re = 1;
    step(); step(); @(negedge clk);
    chk("t3_readback", {dm_ready, dm_rdata}, {1'b1, 16'h5A5A});
    step(); dm_re = 0;

    // Read and write together act as a write
    step(); dm_re = 1; dm_we = 1; dm_addr = 16'h0046; dm_wdata = 16'h1234;
    @(negedge clk);
    chk("t3b_we", {mem_en, mem_we}, 2'b11);
    step(); step(); @(negedge clk);
    chk("t3b_ready", {dm_ready, dm_rdata}, {1'b1, 16'h5A5A});
    step(); dm_re = 0; dm_we = 0;

    // Reset in the middle of a fetch
    step(); if_req = 1; if_addr = 16'h0010;
    step(); rst = 1;
    @(negedge clk);
    chk("t4_rst_cycle", {mem_en, if_ready}, 2'b00);
    step(); rst = 0; if_req = 0;
    @(negedge clk);
    chk("t4_after", {if_ready, mem_en, if_rdata, dm_rdata}, 34'h0);
    for (int i = 0; i < 2; i++) begin
      step(); @(negedge clk);
      chk("t4_no_ready", if_ready, 1'b0);
    end

    // Starvation: data and fetch held high
    step(); dm_re = 1; dm_addr = 16'h0040; if_req = 1; if_addr = 16'h0010;
    ngr = 0; nfetch = 0; first_f = -1;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      if (mem_en === 1'b1) begin
        if (mem_addr == 16'h0010) begin
          nfetch++;
          if (first_f < 0) first_f = ngr;
        end
        ngr++;
      end
      step();
    end
    dm_re = 0; if_req = 0;
    chk("t5_grants", ngr, 7);
`ifdef MEM_ARB_STARVE_GUARD_EN
    chk("t5_first_fetch", first_f, 4);
`else
    chk("t5_no_fetch", nfetch, 0);
`endif
    repeat (4) step();

    // LATENCY=1 back-to-back fetches
    b_if_req = 1; b_if_addr = 16'h0020;
    for (int k = 0; k < 6; k++) begin
      b_mem_rdata = 16'hF000 + 16'(k);
      @(negedge clk);
      chk("l1_en", b_mem_en, (k % 2) == 0);
      chk("l1_ready", b_if_ready, (k % 2) == 1);
      if (k % 2 == 1) chk("l1_rdata", b_if_rdata, 16'hF000 + 16'(k));
      step();
    end
    b_if_req = 0;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
